// File: rtl/swap_scheduler_if.sv
// Swap scheduler bus: game-state control inputs and swap/HUD outputs.
//   enable   : game running (low pauses all counting)
//   restart  : level reset of the schedule
//   fivesec  : one-cycle swap strobe
//   swapped  : current phase, toggles with fivesec
//   secLeft  : whole seconds remaining in the period
//   warning  : high during the pre-swap warning window
//   blink    : square wave during the warning window
// The master modport is the scheduler; the slave modport is its consumer side.
interface swap_scheduler_if;
  logic       enable;
  logic       restart;
  logic       fivesec;
  logic       swapped;
  logic [3:0] secLeft;
  logic       warning;
  logic       blink;

  modport master (
    input  enable,
    input  restart,
    output fivesec,
    output swapped,
    output secLeft,
    output warning,
    output blink
  );

  modport slave (
    output enable,
    output restart,
    input  fivesec,
    input  swapped,
    input  secLeft,
    input  warning,
    input  blink
  );
endinterface

// File: rtl/swap_scheduler.sv
// Periodic ghost swap strobe generator with a pre-swap blinking warning window.
// Ports:
//   clk    : system clock
//   resetN : synchronous active-low reset
//   bus    : swap_scheduler_if master (enable/restart in; fivesec, swapped,
//            secLeft, warning, blink out -- all registered)
module swap_scheduler #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned PERIOD_SEC    = 5,
  parameter int unsigned WARN_SEC      = 1,
  parameter int unsigned BLINK_TICKS   = 6_250_000
) (
  input  logic              clk,
  input  logic              resetN,
  swap_scheduler_if.master  bus
);

  localparam int unsigned CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [CW-1:0] CYC_LAST   = CW'(TICKS_PER_SEC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [3:0]    PERIOD_L   = 4'(PERIOD_SEC);
  localparam logic [3:0]    WARN_L     = 4'(WARN_SEC);
  localparam bit            WARN_EN    = (WARN_SEC != 0);

  typedef enum logic [1:0] {IDLE, COUNT, WARN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cyc, cyc_nxt;
  logic [3:0]    sec_left, sec_left_nxt;
  logic [BW-1:0] blink_cnt, blink_cnt_nxt;
  logic          blink_q, blink_nxt;
  logic          swapped_q, swapped_nxt;
  logic          fivesec_q, fivesec_nxt;
  logic          warning_q;

  // Restart behaves exactly like reset and wins over everything else.
  logic clear;
  assign clear = !resetN || bus.restart;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= IDLE;
      cyc       <= '0;
      sec_left  <= PERIOD_L;
      blink_cnt <= '0;
      blink_q   <= 1'b0;
      swapped_q <= 1'b0;
      fivesec_q <= 1'b0;
      warning_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cyc       <= cyc_nxt;
      sec_left  <= sec_left_nxt;
      blink_cnt <= blink_cnt_nxt;
      blink_q   <= blink_nxt;
      swapped_q <= swapped_nxt;
      fivesec_q <= fivesec_nxt;
      warning_q <= (state_nxt == WARN);
    end
  end

  // Next-state and counter logic; enable low freezes everything.
  always_comb begin
    state_nxt     = state;
    cyc_nxt       = cyc;
    sec_left_nxt  = sec_left;
    blink_cnt_nxt = blink_cnt;
    blink_nxt     = blink_q;
    swapped_nxt   = swapped_q;
    fivesec_nxt   = 1'b0;

    if (bus.enable) begin
      // The IDLE->COUNT edge is itself the first counted cycle.
      if (state == IDLE) state_nxt = COUNT;

      if (cyc == CYC_LAST) begin
        cyc_nxt = '0;
        if (sec_left == 4'd1) begin
          sec_left_nxt = PERIOD_L;
          fivesec_nxt  = 1'b1;
          swapped_nxt  = ~swapped_q;
          state_nxt    = COUNT;
        end else begin
          sec_left_nxt = sec_left - 4'd1;
          if (WARN_EN && (sec_left_nxt == WARN_L)) state_nxt = WARN;
        end
      end else begin
        cyc_nxt = cyc + CW'(1);
      end

      // Blink only runs while staying in WARN; entry and exit clear it.
      if ((state == WARN) && (state_nxt == WARN)) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt_nxt = '0;
          blink_nxt     = ~blink_q;
        end else begin
          blink_cnt_nxt = blink_cnt + BW'(1);
        end
      end else begin
        blink_cnt_nxt = '0;
        blink_nxt     = 1'b0;
      end
    end
  end

  assign bus.fivesec = fivesec_q;
  assign bus.swapped = swapped_q;
  assign bus.secLeft = sec_left;
  assign bus.warning = warning_q;
  assign bus.blink   = blink_q;

endmodule

// File: tb/tb_swap_scheduler.sv
// Directed self-checking bench for swap_scheduler with TICKS_PER_SEC=4,
// PERIOD_SEC=3, BLINK_TICKS=2; dut uses WARN_SEC=1, dut0 uses WARN_SEC=0.
module tb_swap_scheduler;
  logic clk;
  logic resetN;
  logic resetN0;
  int   total;
  int   bad;

  swap_scheduler_if bus ();
  swap_scheduler_if bus0 ();

  swap_scheduler #(
    .TICKS_PER_SEC(4), .PERIOD_SEC(3), .WARN_SEC(1), .BLINK_TICKS(2)
  ) dut (
    .clk(clk), .resetN(resetN), .bus(bus)
  );

  swap_scheduler #(
    .TICKS_PER_SEC(4), .PERIOD_SEC(3), .WARN_SEC(0), .BLINK_TICKS(2)
  ) dut0 (
    .clk(clk), .resetN(resetN0), .bus(bus0)
  );

  always #5 clk = ~clk;

  // secLeft after enabled edge k (index k-1), continuous enable from reset.
  int sec_tab [24] = '{3,3,3,2,2,2,2,1,1,1,1,3,3,3,3,2,2,2,2,1,1,1,1,3};

  // {fivesec, swapped, secLeft[3:0], warning, blink}
  function automatic logic [7:0] obs();
    return {bus.fivesec, bus.swapped, bus.secLeft, bus.warning, bus.blink};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    bus.restart = 1'b0;
    step();
    resetN = 1'b1;
  endtask

  task automatic test_reset();
    bus.enable = 1'b0;
    do_reset();
    total++;
    if (obs() !== 8'b00_0011_00) begin
      bad++;
      $display("FAIL reset_state got=%b exp=%b", obs(), 8'b00_0011_00);
    end
  endtask

  task automatic test_period();
    logic exp_f;
    logic exp_s;
    do_reset();
    bus.enable = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step();
      exp_f = (k == 12) || (k == 24);
      exp_s = (k >= 12) && (k < 24);
      total++;
      if ({bus.fivesec, bus.swapped, bus.secLeft} !== {exp_f, exp_s, 4'(sec_tab[k-1])}) begin
        bad++;
        $display("FAIL period edge=%0d got f=%b s=%b sec=%0d exp f=%b s=%b sec=%0d",
                 k, bus.fivesec, bus.swapped, bus.secLeft, exp_f, exp_s, sec_tab[k-1]);
      end
    end
  endtask

  task automatic test_warning();
    logic exp_w;
    logic exp_b;
    do_reset();
    bus.enable = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      exp_w = (k >= 8) && (k <= 11);
      exp_b = (k == 10) || (k == 11);
      total++;
      if ({bus.warning, bus.blink} !== {exp_w, exp_b}) begin
        bad++;
        $display("FAIL warning edge=%0d got w=%b b=%b exp w=%b b=%b",
                 k, bus.warning, bus.blink, exp_w, exp_b);
      end
    end
  endtask

  task automatic test_pause();
    do_reset();
    bus.enable = 1'b1;
    for (int k = 1; k <= 5; k++) step();
    bus.enable = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      total++;
      if (obs() !== 8'b00_0010_00) begin
        bad++;
        $display("FAIL pause_freeze cyc=%0d got=%b exp=%b", k, obs(), 8'b00_0010_00);
      end
    end
    bus.enable = 1'b1;
    for (int k = 6; k <= 11; k++) step();
    total++;
    if (obs() !== 8'b00_0001_11) begin
      bad++;
      $display("FAIL pause_edge11 got=%b exp=%b", obs(), 8'b00_0001_11);
    end
    // Drop enable exactly in the would-be wrap cycle.
    bus.enable = 1'b0;
    step();
    total++;
    if (obs() !== 8'b00_0001_11) begin
      bad++;
      $display("FAIL pause_at_wrap got=%b exp=%b", obs(), 8'b00_0001_11);
    end
    bus.enable = 1'b1;
    step();
    total++;
    if (obs() !== 8'b11_0011_00) begin
      bad++;
      $display("FAIL pause_wrap got=%b exp=%b", obs(), 8'b11_0011_00);
    end
    step();
    total++;
    if (obs() !== 8'b01_0011_00) begin
      bad++;
      $display("FAIL pause_strobe_end got=%b exp=%b", obs(), 8'b01_0011_00);
    end
  endtask

  task automatic test_restart_at_wrap();
    do_reset();
    bus.enable = 1'b1;
    for (int k = 1; k <= 11; k++) step();
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
    total++;
    if (obs() !== 8'b00_0011_00) begin
      bad++;
      $display("FAIL restart_wrap got=%b exp=%b", obs(), 8'b00_0011_00);
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      total++;
      if (bus.fivesec !== (k == 12)) begin
        bad++;
        $display("FAIL restart_next edge=%0d got f=%b exp f=%b", k, bus.fivesec, (k == 12));
      end
    end
    total++;
    if (bus.swapped !== 1'b1) begin
      bad++;
      $display("FAIL restart_swapped got=%b exp=1", bus.swapped);
    end
  endtask

  task automatic test_reset_in_warn();
    do_reset();
    bus.enable = 1'b1;
    for (int k = 1; k <= 10; k++) step();
    total++;
    if (obs() !== 8'b00_0001_11) begin
      bad++;
      $display("FAIL rstwarn_pre got=%b exp=%b", obs(), 8'b00_0001_11);
    end
    resetN = 1'b0;
    bus.enable = 1'b0;
    step();
    resetN = 1'b1;
    total++;
    if (obs() !== 8'b00_0011_00) begin
      bad++;
      $display("FAIL rstwarn_clear got=%b exp=%b", obs(), 8'b00_0011_00);
    end
    for (int k = 1; k <= 5; k++) begin
      step();
      total++;
      if (obs() !== 8'b00_0011_00) begin
        bad++;
        $display("FAIL rstwarn_idle cyc=%0d got=%b exp=%b", k, obs(), 8'b00_0011_00);
      end
    end
    bus.enable = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 4) begin
        total++;
        if (bus.secLeft !== 4'd2) begin
          bad++;
          $display("FAIL rstwarn_sec got=%0d exp=2", bus.secLeft);
        end
      end
    end
    total++;
    if (bus.fivesec !== 1'b1) begin
      bad++;
      $display("FAIL rstwarn_strobe got=%b exp=1", bus.fivesec);
    end
  endtask

  task automatic test_no_warn();
    logic exp_f;
    bus0.enable = 1'b1;
    resetN0 = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step();
      exp_f = (k == 12) || (k == 24);
      total++;
      if ({bus0.fivesec, bus0.warning, bus0.blink} !== {exp_f, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL nowarn edge=%0d got f=%b w=%b b=%b exp f=%b w=0 b=0",
                 k, bus0.fivesec, bus0.warning, bus0.blink, exp_f);
      end
      if (k == 10) begin
        total++;
        if (bus0.secLeft !== 4'd1) begin
          bad++;
          $display("FAIL nowarn_sec got=%0d exp=1", bus0.secLeft);
        end
      end
      if (k == 12) begin
        total++;
        if (bus0.swapped !== 1'b1) begin
          bad++;
          $display("FAIL nowarn_swapped got=%b exp=1", bus0.swapped);
        end
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    total = 0;
    bad = 0;
    resetN = 1'b0;
    resetN0 = 1'b0;
    bus.enable = 1'b0;
    bus.restart = 1'b0;
    bus0.enable = 1'b0;
    bus0.restart = 1'b0;
    test_reset();
    test_period();
    test_warning();
    test_pause();
    test_restart_at_wrap();
    test_reset_in_warn();
    test_no_warn();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/swap_scheduler.md
# swap_scheduler

Generates the periodic one-cycle swap strobe (`fivesec`) and its companion phase flag that drive the red/green ghost swap block. Counts enabled clock cycles into seconds and seconds into a swap period. Provides a pre-swap warning window with a blink output, so the HUD and ghost sprites can flash before roles exchange. Sits between the game-state controller (enable/restart) and the swap block.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: clock cycles per second; must be ≥ 2.
- `PERIOD_SEC`, default 5: seconds per swap period; range 1..15.
- `WARN_SEC`, default 1: length of the warning window in seconds; must be < `PERIOD_SEC`; 0 disables the warning.
- `BLINK_TICKS`, default 6_250_000: cycles per `blink` half-period; must be ≥ 1.
- `clk`  in  1: system clock.
- `resetN`  in  1: reset, synchronous, active-low.
- `enable`  in  1: game running; low pauses all counting.
- `restart`  in  1: level-reset of the schedule, same pulse that reloads the swap block.
- `fivesec`  out  1: one-cycle swap strobe.
- `swapped`  out  1: current phase (0 = normal, 1 = swapped); toggles together with `fivesec`.
- `secLeft`  out  4: whole seconds remaining in the period, `PERIOD_SEC`..1.
- `warning`  out  1: high during the warning window.
- `blink`  out  1: square wave during the warning window; 0 otherwise.

## Operation
- All outputs are registered. No combinational path from any input to any output.
- Internal state:
  - `cyc`, the cycle counter, 0..`TICKS_PER_SEC`-1, width `$clog2(TICKS_PER_SEC)`.
  - `secLeft`.
  - `blinkCnt`, 0..`BLINK_TICKS`-1.
  - FSM with states IDLE, COUNT, WARN.
- Reset (`resetN`=0 at an edge):
  - FSM → IDLE; `cyc`=0; `secLeft`=`PERIOD_SEC`; `blinkCnt`=0.
  - Outputs: `fivesec`=0, `swapped`=0, `warning`=0, `blink`=0.
- `restart`=1 (while `resetN`=1) does the same as reset. It takes priority over every other event in the same cycle.
- FSM transitions:
  - IDLE → COUNT on the first edge with `enable`=1. That edge also counts as the first enabled cycle.
  - COUNT → WARN at the edge where `secLeft` is loaded with `WARN_SEC`. This never happens if `WARN_SEC`=0.
  - WARN → COUNT at the period wrap.
  - COUNT → COUNT at the period wrap when `WARN_SEC`=0.
- Counting happens only on edges with `enable`=1 in COUNT/WARN, or on the IDLE→COUNT edge:
  - `cyc` increments.
  - When `cyc`=`TICKS_PER_SEC`-1: `cyc`←0 and `secLeft` decrements.
  - Period wrap occurs when `secLeft`=1 and `cyc` wraps. Then `secLeft`←`PERIOD_SEC`, `fivesec`←1, `swapped`←~`swapped`.
- `fivesec` is 1 for exactly the one cycle after a wrap edge and 0 at every other time.
- `enable`=0 freezes `cyc`, `secLeft`, `blinkCnt`, `blink`, state and `swapped`. `fivesec` is 0 during a pause. `warning` holds its value.
- `warning` = (state == WARN).
- `blink` behaviour:
  - Forced to 0 and `blinkCnt` cleared on entry to WARN.
  - In WARN, `blinkCnt` counts enabled cycles. On reaching `BLINK_TICKS`-1 it clears and `blink` toggles.
  - Leaving WARN forces `blink`=0 and `blinkCnt`=0.

## Timing
- Period wrap latency: `PERIOD_SEC`×`TICKS_PER_SEC` enabled cycles from restart/reset to the first `fivesec`, then the same for every subsequent strobe. Paused cycles are not counted.
- `swapped` changes on the same edge that raises `fivesec`. The swap block samples `fivesec` on the following edge, so its internal phase lags `swapped` by one cycle.
- Simultaneous events:
  - `enable` falling in the would-be wrap cycle means no wrap; the wrap occurs on the next enabled edge.
  - `restart` together with a wrap gives no strobe and `swapped`=0.
  - Reset or restart mid-WARN clears `warning` and `blink` on that edge.
- Counter wrap: `cyc` never reaches `TICKS_PER_SEC`. `secLeft` never reads 0.

## Test plan
Parameters for all tests: `TICKS_PER_SEC`=4, `PERIOD_SEC`=3, `WARN_SEC`=1, `BLINK_TICKS`=2.

1. Reset, then hold `enable`=1 → `secLeft` reads 3, then 2 after 4 edges, then 1 after 8 edges. `fivesec`=1 for exactly one cycle after edge 12, `swapped`=1, `secLeft`=3. The next strobe comes after edge 24 with `swapped`=0.
2. Warning window, continuous enable → `warning`=1 after edges 8..11 (4 cycles) and 0 after edge 12. `blink` reads 0,0,1,1 in those cycles and 0 afterwards.
3. Pause: drop `enable` for 10 cycles after edge 5 → all outputs frozen. The first `fivesec` appears after enabled edge 12, i.e. 10 cycles later than in test 1.
4. Assert `restart` on the wrap edge (edge 12) → `fivesec` stays 0, `swapped`=0, `secLeft`=3, FSM IDLE. The next strobe comes 12 enabled edges later.
5. Assert `resetN`=0 for one edge during WARN → `warning`=0, `blink`=0, `secLeft`=3 on that edge. With `enable` held low after reset, the FSM stays IDLE and outputs are unchanged.
6. Reconfigure `WARN_SEC`=0 and run 2 periods → `warning` and `blink` stay 0 throughout. `fivesec` appears after edges 12 and 24.
